// File: rtl/hazard_hold_ctrl.sv
// Stage-2 hold generator: scoreboard of pending writes plus multi-cycle countdown.
// Define HAZARD_FWD_EN to bypass write-back slot matches instead of stalling on them.
module hazard_hold_ctrl #(
    parameter int AW    = 4,
    parameter int DEPTH = 3,
    parameter int LW    = 4,
    parameter int CW    = 16
) (
    input  logic          CLK3,
    input  logic          RST_N,
    input  logic [AW-1:0] SRCA2,
    input  logic [AW-1:0] SRCB2,
    input  logic          RDA2,
    input  logic          RDB2,
    input  logic [AW-1:0] DST2,
    input  logic          WE2,
    input  logic          MC2,
    input  logic [LW-1:0] MCLEN2,
    output logic          HOLD,
    output logic [1:0]    CAUSE,
    output logic          FWD_A,
    output logic          FWD_B,
    output logic [CW-1:0] STALL_CNT
);

    localparam logic [LW-1:0] MC_ONE    = LW'(1);
    localparam logic [CW-1:0] STALL_ONE = CW'(1);

    logic [DEPTH-1:0] r_pv;
    logic [AW-1:0]    r_pd [DEPTH];
    logic [LW-1:0]    r_mcnt;
    logic [CW-1:0]    r_stall_cnt;

    logic [DEPTH-1:0] w_match_a;
    logic [DEPTH-1:0] w_match_b;
    logic             w_live_a;
    logic             w_live_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic             w_haz;
    logic             w_mcs;
    logic             w_hold;

    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match_a[k] = r_pv[k] && (r_pd[k] == SRCA2);
            w_match_b[k] = r_pv[k] && (r_pd[k] == SRCB2);
        end
    end

    assign w_live_a = RDA2 && (SRCA2 != '0);
    assign w_live_b = RDB2 && (SRCB2 != '0);

`ifdef HAZARD_FWD_EN
    // Only a write-back-slot match with no younger match can be bypassed.
    assign w_haz_a = w_live_a && (|w_match_a[DEPTH-2:0]);
    assign w_haz_b = w_live_b && (|w_match_b[DEPTH-2:0]);
    assign w_fwd_a = w_live_a && w_match_a[DEPTH-1] && !(|w_match_a[DEPTH-2:0]);
    assign w_fwd_b = w_live_b && w_match_b[DEPTH-1] && !(|w_match_b[DEPTH-2:0]);
`else
    assign w_haz_a = w_live_a && (|w_match_a);
    assign w_haz_b = w_live_b && (|w_match_b);
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    assign w_haz  = w_haz_a || w_haz_b;
    assign w_mcs  = (r_mcnt != '0);
    assign w_hold = w_mcs || w_haz;

    assign HOLD      = w_hold;
    assign CAUSE     = w_mcs ? 2'b10 : (w_haz ? 2'b01 : 2'b00);
    assign FWD_A     = w_fwd_a;
    assign FWD_B     = w_fwd_b;
    assign STALL_CNT = r_stall_cnt;

    always_ff @(posedge CLK3 or negedge RST_N) begin
        if (!RST_N) begin
            r_pv        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_pd[k] <= '0;
            end
            r_mcnt      <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_pv[k] <= r_pv[k-1];
                r_pd[k] <= r_pd[k-1];
            end
            // A held instruction is replaced by a NOP downstream, so it enters as a bubble.
            r_pv[0] <= WE2 && (DST2 != '0) && !w_hold;
            r_pd[0] <= DST2;

            if (w_mcs) begin
                r_mcnt <= r_mcnt - MC_ONE;
            end else if (MC2 && !w_haz) begin
                r_mcnt <= MCLEN2;
            end

            if (w_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_hold_ctrl.sv
// Self-checking bench for hazard_hold_ctrl; expectations follow HAZARD_FWD_EN when defined.
module tb_hazard_hold_ctrl;

    logic        CLK3;
    logic        RST_N;
    logic [3:0]  SRCA2, SRCB2, DST2, MCLEN2;
    logic        RDA2, RDB2, WE2, MC2;
    logic        HOLD, FWD_A, FWD_B;
    logic [1:0]  CAUSE;
    logic [15:0] STALL_CNT;
    logic        sat_hold, sat_fwd_a, sat_fwd_b;
    logic [1:0]  sat_cause;
    logic [1:0]  sat_cnt;

    hazard_hold_ctrl #(.AW(4), .DEPTH(3), .LW(4), .CW(16)) dut (
        .CLK3(CLK3), .RST_N(RST_N), .SRCA2(SRCA2), .SRCB2(SRCB2), .RDA2(RDA2), .RDB2(RDB2),
        .DST2(DST2), .WE2(WE2), .MC2(MC2), .MCLEN2(MCLEN2), .HOLD(HOLD), .CAUSE(CAUSE),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_CNT(STALL_CNT)
    );

    // Narrow counter copy to reach saturation quickly.
    hazard_hold_ctrl #(.AW(4), .DEPTH(3), .LW(4), .CW(2)) dut_sat (
        .CLK3(CLK3), .RST_N(RST_N), .SRCA2(SRCA2), .SRCB2(SRCB2), .RDA2(RDA2), .RDB2(RDB2),
        .DST2(DST2), .WE2(WE2), .MC2(MC2), .MCLEN2(MCLEN2), .HOLD(sat_hold), .CAUSE(sat_cause),
        .FWD_A(sat_fwd_a), .FWD_B(sat_fwd_b), .STALL_CNT(sat_cnt)
    );

    // Clock and watchdog
    initial begin
        CLK3 = 1'b0;
        forever #5 CLK3 = ~CLK3;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // {HOLD, CAUSE[1:0], FWD_A, FWD_B}
    localparam logic [4:0] E_IDLE = 5'b0_00_00;
    localparam logic [4:0] E_HAZ  = 5'b1_01_00;
    localparam logic [4:0] E_MCS  = 5'b1_10_00;
    localparam logic [4:0] E_FA   = 5'b0_00_10;
    localparam logic [4:0] E_FB   = 5'b0_00_01;

    typedef struct packed {
        logic       rda;
        logic [3:0] sa;
        logic       rdb;
        logic [3:0] sb;
        logic       we;
        logic [3:0] dst;
        logic       mc;
        logic [3:0] mclen;
        logic [4:0] exp;
    } stim_t;

    logic [4:0]  exp_q[$];
    logic [15:0] exp_stall;
    int          n_total;
    int          n_bad;

    function automatic stim_t mk(logic rda, logic [3:0] sa, logic rdb, logic [3:0] sb, logic we,
                                 logic [3:0] dst, logic mc, logic [3:0] mclen, logic [4:0] exp);
        stim_t s;
        s.rda = rda; s.sa = sa; s.rdb = rdb; s.sb = sb; s.we = we; s.dst = dst;
        s.mc = mc; s.mclen = mclen; s.exp = exp;
        return s;
    endfunction

    function automatic stim_t nop(logic [4:0] exp);
        return mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, exp);
    endfunction

    function automatic stim_t wr(logic [3:0] dst, logic [4:0] exp);
        return mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, dst, 1'b0, 4'd0, exp);
    endfunction

    function automatic stim_t ra(logic [3:0] sa, logic [4:0] exp);
        return mk(1'b1, sa, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, exp);
    endfunction

    // Driver: drive at the falling edge, queue the expectation, sample 2 time units later.
    task automatic apply(input stim_t s);
        @(negedge CLK3);
        RDA2 = s.rda; SRCA2 = s.sa; RDB2 = s.rdb; SRCB2 = s.sb;
        WE2 = s.we; DST2 = s.dst; MC2 = s.mc; MCLEN2 = s.mclen;
        exp_q.push_back(s.exp);
        #2;
    endtask

    task automatic test_reset;
        logic [4:0] obs, e;
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), E_IDLE));
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (STALL_CNT !== 16'd0) begin
                n_bad++;
                $display("FAIL reset[%0d] stall_cnt got=%0d want=0", i, STALL_CNT);
            end
        end
        @(negedge CLK3);
        RDA2 = 1'b0; RDB2 = 1'b0; WE2 = 1'b0; MC2 = 1'b0;
        RST_N = 1'b1;
        exp_stall = '0;
    endtask

    task automatic test_dep_pair;
        stim_t s[$];
        logic [4:0] obs, e;
        logic [15:0] base;
        base = exp_stall;
        s.push_back(wr(4'd5, E_IDLE));
        s.push_back(ra(4'd5, E_HAZ));
        s.push_back(ra(4'd5, E_HAZ));
`ifdef HAZARD_FWD_EN
        s.push_back(ra(4'd5, E_FA));
        s.push_back(nop(E_IDLE));
`else
        s.push_back(ra(4'd5, E_HAZ));
        s.push_back(ra(4'd5, E_IDLE));
`endif
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL dep_pair[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (STALL_CNT !== exp_stall) begin
                n_bad++;
                $display("FAIL dep_pair[%0d] stall_cnt got=%0d want=%0d", i, STALL_CNT, exp_stall);
            end
            if (e[4]) exp_stall++;
        end
        n_total++;
`ifdef HAZARD_FWD_EN
        if (STALL_CNT !== base + 16'd2) begin
`else
        if (STALL_CNT !== base + 16'd3) begin
`endif
            n_bad++;
            $display("FAIL dep_pair_total stall_cnt got=%0d base=%0d", STALL_CNT, base);
        end
    endtask

    task automatic test_dep_b;
        stim_t s[$];
        logic [4:0] obs, e;
        s.push_back(wr(4'd9, E_IDLE));
        s.push_back(mk(1'b0, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, E_HAZ));
        s.push_back(mk(1'b0, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, E_HAZ));
`ifdef HAZARD_FWD_EN
        s.push_back(mk(1'b0, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, E_FB));
`else
        s.push_back(mk(1'b0, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, E_HAZ));
        s.push_back(mk(1'b0, 4'd9, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, E_IDLE));
`endif
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL dep_b[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_no_hazard;
        stim_t s[$];
        logic [4:0] obs, e;
        s.push_back(wr(4'd0, E_IDLE));
        s.push_back(mk(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, E_IDLE));
        s.push_back(wr(4'd5, E_IDLE));
        s.push_back(mk(1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0, E_IDLE));
        s.push_back(mk(1'b0, 4'd5, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, E_IDLE));
        s.push_back(mk(1'b0, 4'd5, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, E_IDLE));
        s.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, E_IDLE));
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL no_hazard[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (STALL_CNT !== exp_stall) begin
                n_bad++;
                $display("FAIL no_hazard[%0d] stall_cnt got=%0d want=%0d", i, STALL_CNT, exp_stall);
            end
        end
    endtask

    task automatic test_multi_match;
        stim_t s[$];
        logic [4:0] obs, e;
        s.push_back(wr(4'd5, E_IDLE));
        s.push_back(wr(4'd5, E_IDLE));
        s.push_back(ra(4'd5, E_HAZ));
        s.push_back(ra(4'd5, E_HAZ));
`ifdef HAZARD_FWD_EN
        s.push_back(ra(4'd5, E_FA));
`else
        s.push_back(ra(4'd5, E_HAZ));
        s.push_back(ra(4'd5, E_IDLE));
`endif
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL multi_match[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_multicycle;
        stim_t s[$];
        logic [4:0] obs, e;
        logic [3:0] mq[$];
        s.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, E_IDLE)); mq.push_back(4'd0);
        for (int k = 4; k >= 1; k--) begin
            s.push_back(nop(E_MCS));
            mq.push_back(4'(k));
        end
        s.push_back(nop(E_IDLE)); mq.push_back(4'd0);
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL multicycle[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (dut.r_mcnt !== mq[i]) begin
                n_bad++;
                $display("FAIL multicycle[%0d] mcnt got=%0d want=%0d", i, dut.r_mcnt, mq[i]);
            end
            n_total++;
            if (STALL_CNT !== exp_stall) begin
                n_bad++;
                $display("FAIL multicycle[%0d] stall_cnt got=%0d want=%0d", i, STALL_CNT, exp_stall);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_mc_then_dep;
        stim_t s[$];
        logic [4:0] obs, e;
        s.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 4'd2, E_IDLE));
        s.push_back(ra(4'd7, E_MCS));
        s.push_back(ra(4'd7, E_MCS));
`ifdef HAZARD_FWD_EN
        s.push_back(ra(4'd7, E_FA));
`else
        s.push_back(ra(4'd7, E_HAZ));
        s.push_back(ra(4'd7, E_IDLE));
`endif
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mc_then_dep[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (STALL_CNT !== exp_stall) begin
                n_bad++;
                $display("FAIL mc_then_dep[%0d] stall_cnt got=%0d want=%0d", i, STALL_CNT, exp_stall);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_mc_blocked;
        stim_t s[$];
        logic [4:0] obs, e;
        s.push_back(wr(4'd5, E_IDLE));
        s.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, E_HAZ));
        s.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, E_HAZ));
`ifdef HAZARD_FWD_EN
        s.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, E_FA));
`else
        s.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, E_HAZ));
        s.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, E_IDLE));
`endif
        s.push_back(nop(E_MCS));
        s.push_back(nop(E_MCS));
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL mc_blocked[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_saturation;
        stim_t s[$];
        logic [4:0] obs, e;
        logic [1:0] sat_exp;
        @(negedge CLK3);
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        exp_stall = '0;
        s.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, E_IDLE));
        for (int k = 0; k < 6; k++) s.push_back(nop(E_MCS));
        s.push_back(nop(E_IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            obs = {HOLD, CAUSE, FWD_A, FWD_B};
            e = exp_q.pop_front();
            sat_exp = (exp_stall > 16'd3) ? 2'd3 : exp_stall[1:0];
            n_total++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL saturation[%0d] hold/cause/fwd got=%b want=%b", i, obs, e);
            end
            n_total++;
            if (sat_cnt !== sat_exp) begin
                n_bad++;
                $display("FAIL saturation[%0d] narrow stall_cnt got=%0d want=%0d", i, sat_cnt, sat_exp);
            end
            n_total++;
            if (STALL_CNT !== exp_stall) begin
                n_bad++;
                $display("FAIL saturation[%0d] stall_cnt got=%0d want=%0d", i, STALL_CNT, exp_stall);
            end
            if (e[4]) exp_stall++;
        end
    endtask

    task automatic test_reset_mid_stall;
        logic [4:0] obs, e;
        apply(wr(4'd5, E_IDLE));
        void'(exp_q.pop_front());
        apply(ra(4'd5, E_HAZ));
        obs = {HOLD, CAUSE, FWD_A, FWD_B};
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL mid_stall_pre hold/cause/fwd got=%b want=%b", obs, e);
        end
        #1;
        RST_N = 1'b0;
        #1;
        exp_q.push_back(E_IDLE);
        obs = {HOLD, CAUSE, FWD_A, FWD_B};
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL mid_stall_async hold/cause/fwd got=%b want=%b", obs, e);
        end
        n_total++;
        if (STALL_CNT !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_stall_async stall_cnt got=%0d want=0", STALL_CNT);
        end
        @(negedge CLK3);
        RST_N = 1'b1;
        exp_stall = '0;
        apply(ra(4'd5, E_IDLE));
        obs = {HOLD, CAUSE, FWD_A, FWD_B};
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL mid_stall_after hold/cause/fwd got=%b want=%b", obs, e);
        end
        apply(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, E_IDLE));
        void'(exp_q.pop_front());
        apply(nop(E_MCS));
        obs = {HOLD, CAUSE, FWD_A, FWD_B};
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL mc_stall_pre hold/cause/fwd got=%b want=%b", obs, e);
        end
        #1;
        RST_N = 1'b0;
        #1;
        n_total++;
        if ({HOLD, CAUSE} !== 3'b000) begin
            n_bad++;
            $display("FAIL mc_stall_async hold/cause got=%b want=000", {HOLD, CAUSE});
        end
        @(negedge CLK3);
        RST_N = 1'b1;
        exp_stall = '0;
        apply(nop(E_IDLE));
        obs = {HOLD, CAUSE, FWD_A, FWD_B};
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL mc_stall_after hold/cause/fwd got=%b want=%b", obs, e);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        exp_stall = '0;
        RST_N = 1'b0;
        RDA2 = 1'b0; RDB2 = 1'b0; SRCA2 = '0; SRCB2 = '0;
        WE2 = 1'b0; DST2 = '0; MC2 = 1'b0; MCLEN2 = '0;
        test_reset();
        test_dep_pair();
        test_dep_b();
        test_no_hazard();
        test_multi_match();
        test_multicycle();
        test_mc_then_dep();
        test_mc_blocked();
        test_saturation();
        test_reset_mid_stall();
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard leftover entries got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
